// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller port bundle: ID-stage instruction fields and branch strobe in; enables, strobes, forwarding selects and perf counters out.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic              id_valid;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [RA_W-1:0]   id_dst;
    logic              id_regwrite;
    logic              id_memread;
    logic              Br_taken;

    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exmem_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_memread, Br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_memread, Br_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage hazard/forwarding control; strobes and fwd selects are combinational (0 cycles), shadows/counters update at Clk.
// Backpressure: a RAW hazard holds PC and IF/ID and bubbles ID/EX; a taken branch overrides it with a flush.
module pipe_hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32,
    parameter int FWD_EN   = 1,
    parameter int BR_STAGE = 2,
    parameter int RF_WTHRU = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] dst;
        logic            regwrite;
        logic            memread;
    } shadow_t;

    localparam int IDEX  = 0;
    localparam int EXMEM = 1;
    localparam int MEMWB = 2;

    shadow_t          r_sh [3];
    shadow_t          w_id_rec;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic             w_stall;
    logic             w_flush;
    logic             w_bubble;
    logic             w_exmem_flush;

    function automatic logic match(input shadow_t s, input logic [RA_W-1:0] r);
        return s.valid && s.regwrite && (s.dst == r) && (r != '0);
    endfunction

    function automatic logic raw_hazard(input shadow_t idex, input shadow_t exmem,
                                        input shadow_t memwb, input logic [RA_W-1:0] r);
        if (FWD_EN != 0)
            return idex.memread && match(idex, r);
        return match(idex, r) || match(exmem, r) || (match(memwb, r) && (RF_WTHRU == 0));
    endfunction

    // Youngest producer (EX/MEM) takes precedence over MEM/WB.
    function automatic logic [1:0] fwd_sel(input shadow_t exmem, input shadow_t memwb,
                                           input logic [RA_W-1:0] r);
        if (FWD_EN == 0)       return 2'b00;
        if (match(exmem, r))   return 2'b10;
        if (match(memwb, r))   return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        w_stall = hz.id_valid &&
                  ((hz.id_use_rs && raw_hazard(r_sh[IDEX], r_sh[EXMEM], r_sh[MEMWB], hz.id_rs)) ||
                   (hz.id_use_rt && raw_hazard(r_sh[IDEX], r_sh[EXMEM], r_sh[MEMWB], hz.id_rt)));
        w_flush       = hz.Br_taken;
        w_bubble      = w_flush || w_stall;
        w_exmem_flush = w_flush && (BR_STAGE == 3);

        w_id_rec          = '0;
        w_id_rec.valid    = hz.id_valid;
        w_id_rec.rs       = hz.id_rs;
        w_id_rec.rt       = hz.id_rt;
        w_id_rec.dst      = hz.id_dst;
        w_id_rec.regwrite = hz.id_regwrite;
        w_id_rec.memread  = hz.id_memread;
        if (w_bubble) w_id_rec = '0;
    end

    // Strobes are forced quiet while reset is held, independent of the inputs.
    assign hz.pc_en       = Rst_n && (w_flush || !w_stall);
    assign hz.ifid_en     = Rst_n && (w_flush || !w_stall);
    assign hz.ifid_flush  = Rst_n && w_flush;
    assign hz.idex_bubble = Rst_n && w_bubble;
    assign hz.exmem_flush = Rst_n && w_exmem_flush;
    assign hz.fwd_a       = fwd_sel(r_sh[EXMEM], r_sh[MEMWB], r_sh[IDEX].rs);
    assign hz.fwd_b       = fwd_sel(r_sh[EXMEM], r_sh[MEMWB], r_sh[IDEX].rt);
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
    assign hz.retire_cnt  = r_retire_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sh[IDEX]   <= '0;
            r_sh[EXMEM]  <= '0;
            r_sh[MEMWB]  <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_sh[MEMWB]  <= w_exmem_flush ? '0 : r_sh[EXMEM];
            r_sh[EXMEM]  <= r_sh[IDEX];
            r_sh[IDEX]   <= w_id_rec;
            r_stall_cnt  <= sat_inc(r_stall_cnt, w_stall && !w_flush);
            r_flush_cnt  <= sat_inc(r_flush_cnt, w_flush);
            r_retire_cnt <= sat_inc(r_retire_cnt, r_sh[MEMWB].valid);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: four controller configurations share one ID-stage stimulus stream; each scenario checks the instance it targets.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       br;
    } stim_t;

    logic  clk = 1'b0;
    logic  rst_n;
    stim_t s;
    int    n_vec = 0;
    int    n_err = 0;
    int    st1, st2;

    always #5 clk = ~clk;

    // b0: fwd on, branch in EX.  b1: no fwd, write-through RF.  b2: no fwd, no write-through.
    // b3: fwd on, branch in MEM, 4-bit counters.
    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) b0 ();
    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) b1 ();
    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) b2 ();
    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(4))  b3 ();

    assign {b0.id_valid, b0.id_rs, b0.id_rt, b0.id_use_rs, b0.id_use_rt, b0.id_dst, b0.id_regwrite, b0.id_memread, b0.Br_taken} = s;
    assign {b1.id_valid, b1.id_rs, b1.id_rt, b1.id_use_rs, b1.id_use_rt, b1.id_dst, b1.id_regwrite, b1.id_memread, b1.Br_taken} = s;
    assign {b2.id_valid, b2.id_rs, b2.id_rt, b2.id_use_rs, b2.id_use_rt, b2.id_dst, b2.id_regwrite, b2.id_memread, b2.Br_taken} = s;
    assign {b3.id_valid, b3.id_rs, b3.id_rt, b3.id_use_rs, b3.id_use_rt, b3.id_dst, b3.id_regwrite, b3.id_memread, b3.Br_taken} = s;

    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_EN(1), .BR_STAGE(2), .RF_WTHRU(1))
        u0 (.Clk(clk), .Rst_n(rst_n), .hz(b0));
    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_EN(0), .BR_STAGE(2), .RF_WTHRU(1))
        u1 (.Clk(clk), .Rst_n(rst_n), .hz(b1));
    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_EN(0), .BR_STAGE(2), .RF_WTHRU(0))
        u2 (.Clk(clk), .Rst_n(rst_n), .hz(b2));
    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(4),  .FWD_EN(1), .BR_STAGE(3), .RF_WTHRU(1))
        u3 (.Clk(clk), .Rst_n(rst_n), .hz(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic br);
        s = '{valid: v, rs: rs, rt: rt, use_rs: urs, use_rt: urt, dst: dst, rw: rw, mr: mr, br: br};
    endtask

    task automatic pulse_reset();
        s = '0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        s     = '0;
        tick();
        // Reset state, including a branch strobe that must stay masked.
        set(1, 1, 2, 1, 1, 3, 1, 0, 1);
        #1;
        chk("rst_pc_en",      32'(b0.pc_en),       0);
        chk("rst_ifid_en",    32'(b0.ifid_en),     0);
        chk("rst_ifid_flush", 32'(b0.ifid_flush),  0);
        chk("rst_bubble",     32'(b0.idex_bubble), 0);
        chk("rst_fwd_a",      32'(b0.fwd_a),       0);
        chk("rst_stall_cnt",  b0.stall_cnt,        0);
        chk("rst_retire_cnt", b0.retire_cnt,       0);
        s = '0;
        rst_n = 1'b1;
        tick();

        // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward, no stall.
        set(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        set(1, 3, 5, 1, 1, 4, 1, 0, 0);
        #1;
        chk("t1_pc_en",  32'(b0.pc_en),       1);
        chk("t1_bubble", 32'(b0.idex_bubble), 0);
        tick();
        s = '0;
        #1;
        chk("t1_fwd_a",     32'(b0.fwd_a), 32'b10);
        chk("t1_fwd_b",     32'(b0.fwd_b), 32'b00);
        chk("t1_stall_cnt", b0.stall_cnt,  0);

        // lw $3,0($1) ; add $4,$3,$3 -> one load-use stall then MEM/WB forward on both operands.
        pulse_reset();
        tick();
        set(1, 1, 0, 1, 0, 3, 1, 1, 0);
        tick();
        set(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #1;
        chk("t2_pc_en",   32'(b0.pc_en),       0);
        chk("t2_ifid_en", 32'(b0.ifid_en),     0);
        chk("t2_bubble",  32'(b0.idex_bubble), 1);
        tick();
        #1;
        chk("t2_pc_en_after", 32'(b0.pc_en), 1);
        tick();
        s = '0;
        #1;
        chk("t2_fwd_a",     32'(b0.fwd_a), 32'b01);
        chk("t2_fwd_b",     32'(b0.fwd_b), 32'b01);
        chk("t2_stall_cnt", b0.stall_cnt,  1);

        // Load writing $0 followed by a reader of $0: nothing matches in any mode.
        pulse_reset();
        tick();
        set(1, 1, 2, 1, 1, 0, 1, 1, 0);
        tick();
        set(1, 0, 0, 1, 1, 4, 1, 0, 0);
        #1;
        chk("t3_fwd_pc_en",   32'(b0.pc_en), 1);
        chk("t3_nofwd_pc_en", 32'(b1.pc_en), 1);
        chk("t3_nowt_pc_en",  32'(b2.pc_en), 1);
        tick();
        s = '0;
        #1;
        chk("t3_fwd_a", 32'(b0.fwd_a), 0);
        chk("t3_fwd_b", 32'(b0.fwd_b), 0);

        // No forwarding: dependent of add $3 stalls 2 cycles with write-through, 3 without.
        pulse_reset();
        tick();
        set(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        set(1, 3, 5, 1, 1, 4, 1, 0, 0);
        st1 = 0;
        st2 = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            st1 += int'(!b1.pc_en);
            st2 += int'(!b2.pc_en);
            tick();
        end
        s = '0;
        chk("t4_wt_stall_cycles",   32'(st1),     2);
        chk("t4_nowt_stall_cycles", 32'(st2),     3);
        chk("t4_wt_stall_cnt",      b1.stall_cnt, 2);
        chk("t4_nowt_stall_cnt",    b2.stall_cnt, 3);

        // Taken branch coincident with a load-use stall: flush wins.
        pulse_reset();
        tick();
        set(1, 1, 0, 1, 0, 3, 1, 1, 0);
        tick();
        set(1, 3, 3, 1, 1, 4, 1, 0, 1);
        #1;
        chk("t5_pc_en",       32'(b3.pc_en),       1);
        chk("t5_ifid_en",     32'(b3.ifid_en),     1);
        chk("t5_ifid_flush",  32'(b3.ifid_flush),  1);
        chk("t5_bubble",      32'(b3.idex_bubble), 1);
        chk("t5_exmem_flush", 32'(b3.exmem_flush), 1);
        chk("t5_ex_br_exmem_flush", 32'(b0.exmem_flush), 0);
        tick();
        s = '0;
        #1;
        chk("t5_flush_cnt", 32'(b3.flush_cnt), 1);
        chk("t5_stall_cnt", 32'(b3.stall_cnt), 0);
        chk("t5_ex_br_stall_cnt", b0.stall_cnt, 0);

        // 20 back-to-back dependent ALU ops: 17 retire; 4-bit counter holds at 15.
        pulse_reset();
        tick();
        set(1, 7, 2, 1, 1, 7, 1, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("t6_retire_sat",  32'(b3.retire_cnt), 15);
        chk("t6_retire_wide", b0.retire_cnt,      17);
        chk("t6_fwd_a_live",  32'(b3.fwd_a),      32'b10);
        // Asynchronous reset mid-run, away from any clock edge.
        rst_n = 1'b0;
        #1;
        chk("t6_rst_retire", 32'(b3.retire_cnt), 0);
        chk("t6_rst_flush",  32'(b3.flush_cnt),  0);
        chk("t6_rst_fwd_a",  32'(b3.fwd_a),      0);
        chk("t6_rst_pc_en",  32'(b3.pc_en),      0);
        chk("t6_rst_wide",   b0.retire_cnt,      0);
        s = '0;
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
